// File: rtl/vend_pkg.sv
// Shared types and constants for the vending machine credit controller.
// Credit is a one-hot vector: bit n set means n quarters.
package vend_pkg;

    typedef enum logic [1:0] {
        ACCUM,
        VEND,
        PAYOUT
    } state_t;

    localparam int CREDIT_W    = 7;
    localparam int QUARTER_VAL = 1;
    localparam int DOLLAR_VAL  = 4;

    // Out-of-range counts yield all-zero, which the controller never requests.
    function automatic logic [CREDIT_W-1:0] onehot(input int n);
        logic [CREDIT_W-1:0] v;
        v = '0;
        for (int i = 0; i < CREDIT_W; i++) begin
            v[i] = (i == n);
        end
        return v;
    endfunction

endpackage

// File: rtl/coin_edge.sv
// Rising-event detector for one front-panel level input.
// The previous-level register samples every falling edge regardless of controller state.
module coin_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic level,
    output logic rise
);

    logic prev;

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev <= 1'b0;
        end else begin
            prev <= level;
        end
    end

    assign rise = level & ~prev;

endmodule

// File: rtl/vend_credit_controller.sv
// Credit accumulation, vend and change/refund sequencing for the vending machine.
// All state and outputs update on the falling edge of CLK.
module vend_credit_controller
    import vend_pkg::*;
#(
    parameter int PRICE_Q  = 6,
    parameter int DOLLAR_Q = DOLLAR_VAL
) (
    input  logic                CLK,
    input  logic                RES,
    input  logic                quarter_in,
    input  logic                dollar_in,
    input  logic                cancel_in,
    output logic [CREDIT_W-1:0] credit,
    output logic                vend,
    output logic                change_q,
    output logic                coin_reject,
    output logic                busy
);

    localparam logic [3:0] PRICE4   = 4'(PRICE_Q);
    localparam logic [3:0] DOLLAR4  = 4'(DOLLAR_Q);
    localparam logic [3:0] QUARTER4 = 4'(QUARTER_VAL);

    state_t     state;
    logic [2:0] chg_cnt;
    logic       quarter_ev;
    logic       dollar_ev;
    logic       cancel_ev;
    logic       coin_ev;
    logic [2:0] cur_n;
    logic [3:0] coin_val;
    logic [3:0] total;

    coin_edge u_quarter (.clk(CLK), .rst_n(RES), .level(quarter_in), .rise(quarter_ev));
    coin_edge u_dollar  (.clk(CLK), .rst_n(RES), .level(dollar_in),  .rise(dollar_ev));
    coin_edge u_cancel  (.clk(CLK), .rst_n(RES), .level(cancel_in),  .rise(cancel_ev));

    // Decode the one-hot credit and form the 4-bit running total (max 5 + a dollar).
    always_comb begin
        cur_n = '0;
        for (int i = 0; i < CREDIT_W; i++) begin
            if (credit[i]) begin
                cur_n = 3'(i);
            end
        end
        coin_ev  = dollar_ev | quarter_ev;
        coin_val = dollar_ev ? DOLLAR4 : QUARTER4;
        total    = {1'b0, cur_n} + coin_val;
    end

    always_ff @(negedge CLK or negedge RES) begin
        if (!RES) begin
            state       <= ACCUM;
            credit      <= onehot(0);
            chg_cnt     <= '0;
            vend        <= 1'b0;
            change_q    <= 1'b0;
            coin_reject <= 1'b0;
            busy        <= 1'b0;
        end else begin
            vend        <= 1'b0;
            change_q    <= 1'b0;
            coin_reject <= 1'b0;
            case (state)
                ACCUM: begin
                    busy <= 1'b0;
                    // Cancel outranks any coin arriving in the same cycle.
                    if (cancel_ev) begin
                        coin_reject <= coin_ev;
                        if (cur_n != 3'd0) begin
                            chg_cnt  <= cur_n;
                            state    <= PAYOUT;
                            change_q <= 1'b1;
                            busy     <= 1'b1;
                        end
                    end else if (coin_ev) begin
                        coin_reject <= dollar_ev & quarter_ev;
                        if (total < PRICE4) begin
                            credit <= onehot(int'(total));
                        end else begin
                            chg_cnt <= 3'(total - PRICE4);
                            credit  <= onehot(0);
                            state   <= VEND;
                            vend    <= 1'b1;
                            busy    <= 1'b1;
                        end
                    end
                end
                VEND: begin
                    coin_reject <= coin_ev;
                    if (chg_cnt != 3'd0) begin
                        credit   <= onehot(int'(chg_cnt));
                        state    <= PAYOUT;
                        change_q <= 1'b1;
                        busy     <= 1'b1;
                    end else begin
                        state <= ACCUM;
                        busy  <= 1'b0;
                    end
                end
                PAYOUT: begin
                    coin_reject <= coin_ev;
                    if (chg_cnt <= 3'd1) begin
                        chg_cnt <= '0;
                        credit  <= onehot(0);
                        state   <= ACCUM;
                        busy    <= 1'b0;
                    end else begin
                        chg_cnt  <= chg_cnt - 3'd1;
                        credit   <= onehot(int'(chg_cnt - 3'd1));
                        change_q <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                default: begin
                    state <= ACCUM;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/vend_credit_controller.md
Name: vend_credit_controller

Overview:
- Next-state and output controller for the vending machine's one-hot credit register (S0..S6 = $0.00..$1.50 in quarter steps).
- Accepts quarter/dollar coin events and cancel requests, and accumulates credit.
- Issues a vend pulse when credit reaches the price, then pays change or refunds one quarter per cycle.
- Sits between front-panel coin/button inputs and the credit display/dispense logic.

Parameters:
- PRICE_Q, 6, item price in quarters (legal 1..6; 6 = $1.50)
- DOLLAR_Q, 4, value of a dollar coin in quarters

Ports:
- CLK  in  1  system clock; all registers update on the falling edge
- RES  in  1  asynchronous active-low reset
- quarter_in  in  1  quarter-slot level, synchronous to CLK
- dollar_in  in  1  dollar-slot level, synchronous to CLK
- cancel_in  in  1  cancel-button level, synchronous to CLK
- credit  out  7  one-hot credit/remaining-change indicator; bit n = n quarters
- vend  out  1  dispense-item pulse
- change_q  out  1  eject-one-quarter pulse
- coin_reject  out  1  coin-not-accepted pulse
- busy  out  1  high while in VEND or PAYOUT

Behaviour:
- Reset (RES low, asynchronous):
  - state = ACCUM, credit = 7'b0000001, chg_cnt = 0.
  - Previous-level registers cleared.
  - vend, change_q, coin_reject and busy all 0.
  - Reset mid-VEND or mid-PAYOUT abandons any pending change.
- Edge detect: event = level & ~prev_level. Previous-level registers update every cycle in every state, so a level held high through a busy period never produces a late event.
- States: ACCUM, VEND, PAYOUT. All outputs are registered.
  - vend = (state==VEND), change_q = (state==PAYOUT), busy = (state!=ACCUM).
- ACCUM, priority cancel > dollar > quarter. Only one event is acted on per cycle; the others are handled as follows:
  - cancel with credit n>0: chg_cnt <= n; -> PAYOUT. Credit holds n.
  - cancel with credit 0: no-op.
  - Coin accepted: total = n + value.
    - If total < PRICE_Q: credit <= onehot(total); stay in ACCUM.
    - If total >= PRICE_Q: chg_cnt <= total - PRICE_Q; credit <= onehot(0); -> VEND.
  - Any coin event that loses priority in the same cycle: coin_reject pulses for 1 cycle on the next edge.
- VEND (exactly 1 cycle):
  - If chg_cnt > 0: credit <= onehot(chg_cnt); -> PAYOUT.
  - Otherwise -> ACCUM.
- PAYOUT: change_q is high for chg_cnt consecutive cycles.
  - Each cycle: chg_cnt decrements and credit shows the remaining count.
  - When chg_cnt == 1: credit <= onehot(0); -> ACCUM.
- Coin events in VEND/PAYOUT: rejected (coin_reject pulse); credit and chg_cnt unchanged.
- Cancel events in VEND/PAYOUT: ignored.
- Width rules:
  - Maximum total is 5 + DOLLAR_Q = 9, so total uses a 4-bit intermediate.
  - chg_cnt is 3 bits; maximum change is 3 with PRICE_Q=6.
  - credit is always exactly one-hot; an all-zero or multi-hot credit is a bug.
- Latency:
  - A coin event updates credit at the next falling edge.
  - The vend pulse occurs 1 cycle after the completing coin.
  - The first change quarter occurs 2 cycles after the completing coin.

Decomposition:
- Package vend_pkg holds:
  - state enum {ACCUM, VEND, PAYOUT}
  - constant CREDIT_W = 7
  - constants for quarter/dollar values
  - function onehot(int n) returning the 7-bit one-hot vector
- Sub-module: coin_edge, one instance per input (falling-edge register plus rising-event output, async active-low reset).

Test Plan:
- RES low mid-PAYOUT with chg_cnt 2 -> outputs drop immediately to reset values (credit 7'b0000001, change_q 0); no further change_q pulses after release.
- 6 quarter events -> credit steps 0000010, 0000100, ... 0100000; on the 6th coin, credit = 0000001 and vend pulses 1 cycle; no change_q.
- Quarter, then quarter, then dollar (total 6) -> vend 1 cycle; change_q 0.
- 3 quarters, then dollar (total 7) -> vend, then change_q for 1 cycle; credit shows 0000010 then 0000001.
- 2 quarters, then cancel -> change_q pulses 2 consecutive cycles, credit 0000100 -> 0000010 -> 0000001.
- quarter_in and dollar_in rise in the same cycle at credit 0 -> credit = 0010000, coin_reject pulses once.
- Quarter event during VEND -> coin_reject pulses once, credit unchanged.
- quarter_in held high for 10 cycles -> exactly one credit increment.
